// File: rtl/mult_control.sv
// Sequencer for a 32-step shift-and-add multiplier: load, 32 shift edges, then a four-phase result handshake.
// Optional MULT_CONTROL_PERF_CNT_EN adds done_cnt, a wrapping count of completed operations.
module mult_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       lsb,
  output logic       w_ctrl,
  output logic       srl_ctrl,
  output logic       alu_en,
  output logic       ready,
  output logic       busy,
  output logic [5:0] iter_cnt
`ifdef MULT_CONTROL_PERF_CNT_EN
  ,
  output logic [15:0] done_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg;

  // The final shift edge is the one that sees 31 and writes 32.
  logic last_shift;
  assign last_shift = (state_reg == SHIFT) && (iter_cnt == 6'd31);

  // Outputs are registered alongside the state, so each one always matches the decode of state_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      w_ctrl    <= 1'b0;
      srl_ctrl  <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      iter_cnt  <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (run) begin
            state_reg <= LOAD;
            w_ctrl    <= 1'b1;
            busy      <= 1'b1;
          end
          iter_cnt <= 6'd0;
        end
        LOAD: begin
          state_reg <= SHIFT;
          w_ctrl    <= 1'b0;
          srl_ctrl  <= 1'b1;
          busy      <= 1'b1;
          iter_cnt  <= 6'd0;
        end
        SHIFT: begin
          iter_cnt <= iter_cnt + 6'd1;
          if (last_shift) begin
            state_reg <= DONE;
            srl_ctrl  <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
          end
        end
        DONE: begin
          if (!run) begin
            state_reg <= IDLE;
            ready     <= 1'b0;
            iter_cnt  <= 6'd0;
          end
        end
        default: begin
          state_reg <= IDLE;
          w_ctrl    <= 1'b0;
          srl_ctrl  <= 1'b0;
          ready     <= 1'b0;
          busy      <= 1'b0;
          iter_cnt  <= 6'd0;
        end
      endcase
    end
  end

  assign alu_en = srl_ctrl & lsb;

`ifdef MULT_CONTROL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_cnt <= 16'd0;
    end else if (last_shift) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_control.sv
// Directed bench for mult_control: a vector table for one full operation plus hand-written
// sequences for handshake hold, asynchronous reset mid-shift, and the optional done counter.
module tb_mult_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       lsb;
  logic       w_ctrl, srl_ctrl, alu_en, ready, busy;
  logic [5:0] iter_cnt;
`ifdef MULT_CONTROL_PERF_CNT_EN
  logic [15:0] done_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  mult_control dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .lsb      (lsb),
    .w_ctrl   (w_ctrl),
    .srl_ctrl (srl_ctrl),
    .alu_en   (alu_en),
    .ready    (ready),
    .busy     (busy),
    .iter_cnt (iter_cnt)
`ifdef MULT_CONTROL_PERF_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {w_ctrl, srl_ctrl, alu_en, ready, busy, iter_cnt}
  typedef struct {
    logic        run;
    logic        lsb;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[37];

  function automatic logic [10:0] outs();
    return {w_ctrl, srl_ctrl, alu_en, ready, busy, iter_cnt};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, return at the following negedge.
  task automatic step(input logic r, input logic l);
    run = r;
    lsb = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for ready, got 0 expected 1", name);
    end
  endtask

  // Load and shift strobes must never overlap.
  always @(negedge clk) begin
    if (!reset && w_ctrl && srl_ctrl) begin
      n_vec++;
      n_err++;
      $display("FAIL exclusive: w_ctrl=1 srl_ctrl=1 expected not both");
    end
  end

  initial begin
    int srl_count;
    int n;

    // Table: run sampled at edge 0, LOAD, 32 SHIFT edges with run/lsb wiggling, DONE hold, release.
    vecs[0] = '{1'b1, 1'b0, {5'b10001, 6'd0}};
    for (int k = 1; k <= 32; k++) begin
      vecs[k].run = ((k % 3) == 0);
      vecs[k].lsb = k[0];
      vecs[k].exp = {1'b0, 1'b1, k[0], 1'b0, 1'b1, 6'(k - 1)};
    end
    vecs[33] = '{1'b1, 1'b1, {5'b00010, 6'd32}};
    vecs[34] = '{1'b1, 1'b0, {5'b00010, 6'd32}};
    vecs[35] = '{1'b0, 1'b1, 11'd0};
    vecs[36] = '{1'b0, 1'b1, 11'd0};

    reset = 1'b1;
    run   = 1'b0;
    lsb   = 1'b0;
    #1;
    check("reset_state", 16'(outs()), 16'd0);
    @(negedge clk);
    @(negedge clk);
    step(1'b1, 1'b1);
    check("reset_with_run", 16'(outs()), 16'd0);
    reset = 1'b0;
    step(1'b0, 1'b1);
    check("idle_lsb_high", 16'(outs()), 16'd0);

    for (int i = 0; i < 37; i++) begin
      step(vecs[i].run, vecs[i].lsb);
      check($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp));
    end

    // Handshake: run held high keeps DONE, drop releases, rerun gives a fresh 32-shift pass.
    step(1'b1, 1'b0);
    check("hs_load", 16'(outs()), {5'd0, 5'b10001, 6'd0});
    run = 1'b0;
    wait_ready("hs_first", 40);
    run = 1'b1;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      step(1'b1, 1'b0);
      if (ready && busy == 1'b0 && iter_cnt == 6'd32) n++;
    end
    check("hs_hold_50", 16'(n), 16'd50);
    step(1'b0, 1'b0);
    check("hs_release", 16'(outs()), 16'd0);
    step(1'b1, 1'b0);
    check("hs_rerun_load", 16'(outs()), {5'd0, 5'b10001, 6'd0});
    run = 1'b0;
    srl_count = 0;
    n = 0;
    while (!ready && n < 40) begin
      step(1'b0, 1'b0);
      if (srl_ctrl) srl_count++;
      n++;
    end
    check("hs_rerun_shifts", 16'(srl_count), 16'd32);
    check("hs_rerun_done", 16'(outs()), {5'd0, 5'b00010, 6'd32});
    step(1'b0, 1'b0);

    // Asynchronous reset at iter_cnt==17, checked before any further clock edge.
    step(1'b1, 1'b0);
    run = 1'b0;
    n = 0;
    while (iter_cnt != 6'd17 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_iter17", 16'(iter_cnt), 16'd17);
    #2 reset = 1'b1;
    run = 1'b1;
    #1;
    check("mid_reset_async", 16'(outs()), 16'd0);
    @(negedge clk);
    step(1'b1, 1'b0);
    check("mid_reset_hold", 16'(outs()), 16'd0);
    reset = 1'b0;
    step(1'b1, 1'b0);
    check("post_reset_load", 16'(outs()), {5'd0, 5'b10001, 6'd0});
    run = 1'b0;
    wait_ready("post_reset_done", 40);
    check("post_reset_iter", 16'(iter_cnt), 16'd32);
    step(1'b0, 1'b0);

`ifdef MULT_CONTROL_PERF_CNT_EN
    reset = 1'b1;
    #1;
    check("perf_reset", done_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int op = 0; op < 3; op++) begin
      step(1'b1, 1'b0);
      run = 1'b0;
      wait_ready("perf_op", 40);
      step(1'b0, 1'b0);
    end
    check("perf_three", done_cnt, 16'd3);
    force dut.done_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.done_cnt;
    step(1'b1, 1'b0);
    run = 1'b0;
    wait_ready("perf_wrap_op", 40);
    check("perf_wrap", done_cnt, 16'h0000);
    step(1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
